// File: rtl/shift_arb_pkg.sv
// Purpose : shared FSM encoding, requester ids and operand bundle for shift_arbiter.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
//
// Contents: state_t (S_IDLE/S_EXEC/S_RESP), RQ0/RQ1 ids, OP_W operand bundle
//           width and the op_t packed operand bundle.
package shift_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic RQ0 = 1'b0;
   localparam logic RQ1 = 1'b1;

   // data + shift amount + direction + arithmetic flag
   localparam int OP_W = 32 + 5 + 1 + 1;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  sa;
      logic        right;
      logic        arith;
   } op_t;

endpackage

// File: rtl/shift.sv
// Purpose : 32-bit combinational barrel shifter (left logical, right logical, right arithmetic).
// Latency : 0 cycles, purely combinational.
// Backpr. : none; output follows inputs.
//
// Ports   : d     in  32  data to shift
//           sa    in  5   shift amount (0 passes d unchanged)
//           right in  1   1 = shift right, 0 = shift left
//           arith in  1   1 = sign-fill on right shifts; ignored for left shifts
//           sh    out 32  shifted result
module shift (
   input  logic [31:0] d,
   input  logic [4:0]  sa,
   input  logic        right,
   input  logic        arith,
   output logic [31:0] sh
);

   always_comb begin
      if (!right) begin
         sh = d << sa;
      end else if (arith) begin
         sh = $unsigned($signed(d) >>> sa);
      end else begin
         sh = d >> sa;
      end
   end

endmodule

// File: rtl/shift_arbiter.sv
// Purpose : shares one barrel shifter between two requesters with round-robin arbitration.
// Latency : accept at edge k, res_valid after edge k+1; at most one op per 2 cycles.
// Backpr. : result held stable until res_ready; no grant while a result is unaccepted.
//
// Ports   : clk, rst (synchronous, active-high)
//           rqN_valid/rqN_ready handshake, rqN_d/rqN_sa/rqN_right/rqN_arith/rqN_tag operands (N=0,1)
//           res_valid/res_ready handshake, res_data, res_id, res_tag result
// Config  : SHIFT_ARB_FIXED_PRIO_EN defined -> requester 0 always wins contention
//           (no last_grant state, requester 1 may starve); undefined -> round-robin.
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             rq0_valid,
   output logic             rq0_ready,
   input  logic [31:0]      rq0_d,
   input  logic [4:0]       rq0_sa,
   input  logic             rq0_right,
   input  logic             rq0_arith,
   input  logic [TAG_W-1:0] rq0_tag,

   input  logic             rq1_valid,
   output logic             rq1_ready,
   input  logic [31:0]      rq1_d,
   input  logic [4:0]       rq1_sa,
   input  logic             rq1_right,
   input  logic             rq1_arith,
   input  logic [TAG_W-1:0] rq1_tag,

   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic             res_id,
   output logic [TAG_W-1:0] res_tag
);

   state_t           state;
   state_t           state_nxt;

   logic [OP_W-1:0]  op_q;
   logic             op_id_q;
   logic [TAG_W-1:0] op_tag_q;
   op_t              op_cur;
   op_t              grant_op;
   logic [31:0]      sh;

   logic             can_grant;
   logic             gnt0;
   logic             gnt1;
   logic             grant;

   // A new op can only enter when nothing is in flight, or when the held
   // result leaves this very cycle; rst gating keeps both readies low in reset.
   assign can_grant = !rst && ((state == S_IDLE) || ((state == S_RESP) && res_ready));

`ifdef SHIFT_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt0 = can_grant && rq0_valid;
      gnt1 = can_grant && rq1_valid && !rq0_valid;
   end
`else
   logic last_grant;

   // On contention requester 1 wins only if requester 0 was granted last.
   always_comb begin
      gnt1 = can_grant && rq1_valid && (!rq0_valid || (last_grant == RQ0));
      gnt0 = can_grant && rq0_valid && !gnt1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= RQ1;
      end else if (gnt0 || gnt1) begin
         last_grant <= gnt1 ? RQ1 : RQ0;
      end
   end
`endif

   assign grant     = gnt0 || gnt1;
   assign rq0_ready = gnt0;
   assign rq1_ready = gnt1;
   assign res_valid = (state == S_RESP);

   always_comb begin
      grant_op = '0;
      if (gnt1) begin
         grant_op.d     = rq1_d;
         grant_op.sa    = rq1_sa;
         grant_op.right = rq1_right;
         grant_op.arith = rq1_arith;
      end else begin
         grant_op.d     = rq0_d;
         grant_op.sa    = rq0_sa;
         grant_op.right = rq0_right;
         grant_op.arith = rq0_arith;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (res_ready) state_nxt = grant ? S_EXEC : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= '0;
         op_id_q  <= RQ0;
         op_tag_q <= '0;
         res_data <= '0;
         res_id   <= RQ0;
         res_tag  <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            op_q     <= grant_op;
            op_id_q  <= gnt1 ? RQ1 : RQ0;
            op_tag_q <= gnt1 ? rq1_tag : rq0_tag;
         end
         if (state == S_EXEC) begin
            res_data <= sh;
            res_id   <= op_id_q;
            res_tag  <= op_tag_q;
         end
      end
   end

   assign op_cur = op_t'(op_q);

   shift u_shift (
      .d     (op_cur.d),
      .sa    (op_cur.sa),
      .right (op_cur.right),
      .arith (op_cur.arith),
      .sh    (sh)
   );

endmodule
